// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Main control FSM for the multicycle ARMv4 datapath. It
//               sequences the fetch, decode, execute, memory and writeback
//               steps and decodes the ALU control.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       NoWrite,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     r_state;
    logic       r_nowrite;

    logic       w_irwrite;
    logic       w_nextpc;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic       w_aluop;
    logic       w_in_exec;
    logic [1:0] w_aluctl;
    logic       w_arith;
    logic       w_nw_dec;
    logic       w_known;

    assign w_in_exec = (r_state == S_EXECR) || (r_state == S_EXECI);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_nowrite <= 1'b0;
        end else begin
            // Capture the decode in execute, hold it into writeback, clear elsewhere
            if (w_in_exec)
                r_nowrite <= w_nw_dec;
            else if (r_state != S_ALUWB)
                r_nowrite <= 1'b0;
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        2'b01:   r_state <= S_MEMADR;
                        2'b00:   r_state <= Funct[5] ? S_EXECI : S_EXECR;
                        2'b10:   r_state <= S_BRANCH;
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXECR:  r_state <= S_ALUWB;
                S_EXECI:  r_state <= S_ALUWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_irwrite = 1'b0;
        w_nextpc  = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_branch  = 1'b0;
        w_aluop   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_nextpc  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_regw    = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
            end
            S_EXECR:  w_aluop = 1'b1;
            S_EXECI: begin
                ALUSrcB = 2'b01;
                w_aluop = 1'b1;
            end
            S_ALUWB:  w_regw = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_branch  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_aluctl = 2'b00;
        w_arith  = 1'b0;
        w_nw_dec = 1'b0;
        w_known  = 1'b1;
        case (Funct[4:1])
            4'b0100: w_arith = 1'b1;
            4'b0010: begin
                w_aluctl = 2'b01;
                w_arith  = 1'b1;
            end
            4'b0000: w_aluctl = 2'b10;
            4'b1100: w_aluctl = 2'b11;
            4'b1010: begin
                w_aluctl = 2'b01;
                w_arith  = 1'b1;
                w_nw_dec = 1'b1;
            end
            default: begin
                w_nw_dec = 1'b1;
                w_known  = 1'b0;
            end
        endcase
    end

    // Write requests are suppressed while reset is held so an abandoned
    // instruction never commits anything.
    assign IRWrite    = w_irwrite & ~reset;
    assign NextPC     = w_nextpc & ~reset;
    assign RegW       = w_regw & ~reset;
    assign MemW       = w_memw & ~reset;
    assign PCS        = ~reset & (w_branch | (w_regw & (Rd == 4'hF)));
    assign ALUControl = w_aluop ? w_aluctl : 2'b00;
    assign FlagW      = (w_aluop && w_known && !reset) ? {Funct[0], Funct[0] & w_arith} : 2'b00;
    assign NoWrite    = reset ? 1'b0 :
                        w_in_exec ? w_nw_dec :
                        (r_state == S_ALUWB) ? r_nowrite : 1'b0;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Scoreboard bench for multicycle_control_fsm; per-cycle
//               expected control vectors are queued and compared on negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW, NoWrite;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW;
    logic [3:0] state;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .ALUControl(ALUControl), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [23:0] exp;
        logic [23:0] mask;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        errors = 0;
    int        checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Vector: {state, IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
    //          ImmSrc, RegSrc, ALUControl, FlagW, PCS, RegW, MemW, NoWrite}
    function automatic logic [23:0] expv(input int st, input logic [1:0] op,
                                         input logic [5:0] f, input logic [3:0] rd,
                                         input logic rst);
        logic       irw, npc, adr, srca, pcs, regw, memw, nw, br, arith, nwdec, known;
        logic [1:0] rs, srcb, aluc, fw, alu_dec;
        irw = 0; npc = 0; adr = 0; srca = 0; regw = 0; memw = 0; nw = 0; br = 0;
        rs = 2'b00; srcb = 2'b00; aluc = 2'b00; fw = 2'b00;
        arith = 0; nwdec = 0; known = 1; alu_dec = 2'b00;
        case (f[4:1])
            4'b0100: arith = 1;
            4'b0010: begin alu_dec = 2'b01; arith = 1; end
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            4'b1010: begin alu_dec = 2'b01; arith = 1; nwdec = 1; end
            default: begin nwdec = 1; known = 0; end
        endcase
        case (st)
            0: begin irw = 1; npc = 1; srca = 1; srcb = 2'b10; rs = 2'b10; end
            1: begin srca = 1; srcb = 2'b10; rs = 2'b10; end
            2: srcb = 2'b01;
            3: adr = 1;
            4: begin rs = 2'b01; regw = 1; end
            5: begin adr = 1; memw = 1; end
            6, 7: begin
                srcb = (st == 7) ? 2'b01 : 2'b00;
                aluc = alu_dec;
                fw   = known ? {f[0], f[0] & arith} : 2'b00;
                nw   = nwdec;
            end
            8: begin regw = 1; nw = nwdec; end
            9: begin srcb = 2'b01; rs = 2'b10; br = 1; end
            default: ;
        endcase
        pcs = br | (regw & (rd == 4'hF));
        if (rst) begin
            irw = 0; npc = 0; regw = 0; memw = 0; pcs = 0; fw = 2'b00; nw = 0;
        end
        return {st[3:0], irw, npc, adr, rs, srca, srcb, op,
                (op == 2'b01), (op == 2'b10), aluc, fw, pcs, regw, memw, nw};
    endfunction

    // One cycle: drive inputs just after the edge and queue what that cycle must show
    task automatic step(input int st, input logic [1:0] op, input logic [5:0] f,
                        input logic [3:0] rd, input logic rst, input string name);
        sb_entry_t e;
        @(posedge clk);
        #1;
        reset = rst; Op = op; Funct = f; Rd = rd;
        e.tag  = $sformatf("%s st%0d", name, st);
        e.exp  = expv(st, op, f, rd, rst);
        // NoWrite during execute is only pinned down once it reaches writeback
        e.mask = (st == 6 || st == 7) ? 24'hFFFFFE : 24'hFFFFFF;
        sb.push_back(e);
    endtask

    task automatic instr(input string name, input logic [1:0] op,
                         input logic [5:0] f, input logic [3:0] rd);
        int seq[$];
        seq = '{0, 1};
        case (op)
            2'b01: if (f[0]) seq = '{0, 1, 2, 3, 4}; else seq = '{0, 1, 2, 5};
            2'b00: seq = f[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
            2'b10: seq = '{0, 1, 9};
            default: ;
        endcase
        foreach (seq[i]) step(seq[i], op, f, rd, 1'b0, name);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_entry_t e;
            logic [23:0] obs;
            e = sb.pop_front();
            obs = {state, IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
                   ImmSrc, RegSrc, ALUControl, FlagW, PCS, RegW, MemW, NoWrite};
            check_eq(e.tag, {8'h0, obs & e.mask}, {8'h0, e.exp & e.mask});
        end
    end

    initial begin
        reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'h0;
        step(0, 2'b00, 6'b0, 4'h0, 1'b1, "reset");
        step(0, 2'b00, 6'b0, 4'h0, 1'b1, "reset");
        instr("ADDS",   2'b00, 6'b001001, 4'h1);
        instr("CMPI",   2'b00, 6'b110101, 4'h0);
        instr("LDRPC",  2'b01, 6'b011001, 4'hF);
        instr("STR",    2'b01, 6'b011000, 4'h2);
        instr("B",      2'b10, 6'b100000, 4'h0);
        instr("OP11",   2'b11, 6'b111111, 4'hF);
        instr("SUBPC",  2'b00, 6'b000100, 4'hF);
        instr("ANDI",   2'b00, 6'b100000, 4'h3);
        instr("ORRS",   2'b00, 6'b011001, 4'h4);
        instr("EOR",    2'b00, 6'b000010, 4'h5);
        // Reset in the middle of a load: abandoned, no writeback afterwards
        step(0, 2'b01, 6'b011001, 4'h7, 1'b0, "LDRRST");
        step(1, 2'b01, 6'b011001, 4'h7, 1'b0, "LDRRST");
        step(2, 2'b01, 6'b011001, 4'h7, 1'b0, "LDRRST");
        step(3, 2'b01, 6'b011001, 4'h7, 1'b1, "LDRRST");
        step(0, 2'b01, 6'b011001, 4'h7, 1'b1, "LDRRST");
        instr("ADDPOST", 2'b00, 6'b001000, 4'h6);
        step(0, 2'b00, 6'b001000, 4'h6, 1'b0, "END");
        @(negedge clk);
        #1;
        check_eq("sb_drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control unit for the multicycle ARMv4 datapath. It decodes Op/Funct/Rd from the instruction register and sequences fetch, decode, execute, memory and writeback over several cycles. It produces the unconditioned write requests (PCS, RegW, MemW, FlagW, NoWrite) that conditional_logic gates with CondEx. It also produces all datapath mux selects and the ALU control.

Parameters:
None. State encoding and width (4 bits) are fixed.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Op  input  2  Instr[27:26]
Funct  input  6  Instr[25:20] (I, cmd[3:0], S/L)
Rd  input  4  Instr[15:12]
IRWrite  output  1  instruction register load enable
NextPC  output  1  unconditional PC write (PC+4 in FETCH)
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  1  0 = RD1, 1 = PC
ALUSrcB  output  2  00 RD2/shifted, 01 ExtImm, 10 constant 4
ImmSrc  output  2  extender select (= Op)
RegSrc  output  2  [0] = (Op==10), [1] = (Op==01)
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
FlagW  output  2  [1] NZ write request, [0] CV write request
PCS  output  1  conditional PC write request
RegW  output  1  register write request
MemW  output  1  memory write request
NoWrite  output  1  suppress register write (CMP)
state  output  4  current state, for debug and verification

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10–15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH (treated as NOP).
  - MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECR/EXECI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Moore outputs per state. Anything not listed is 0; ALUOp is internal.
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1 (internal).
- ALU decode:
  - ALUOp=0: ALUControl=00, FlagW=00, NoWrite=0.
  - ALUOp=1, by Funct[4:1]: 0100 ADD -> 00; 0010 SUB -> 01; 0000 AND -> 10; 1100 ORR -> 11; 1010 CMP -> 01 with NoWrite=1.
  - ALUOp=1, any other cmd: ALUControl=00, FlagW=00, NoWrite=1.
  - FlagW[1] = Funct[0]. FlagW[0] = Funct[0] & (cmd is ADD, SUB or CMP). Both are active only in EXECR/EXECI.
- NoWrite is registered from the EXECR/EXECI decode and held through ALUWB. It is cleared in every other state.
- PCS = Branch | (RegW & Rd==4'hF). Combinational from state and Rd.
- ImmSrc and RegSrc are combinational from Op in all states.
- Reset:
  - State is set to FETCH on the first clk edge where reset=1.
  - While reset=1, IRWrite, NextPC, RegW, MemW, PCS, FlagW and NoWrite are forced to 0, overriding the state outputs.
  - Reset asserted in the middle of an instruction abandons it; no write request is issued on or after that edge.
  - The first FETCH outputs appear in the cycle after reset deasserts.
- Inputs are sampled every cycle. The datapath holds Instr stable from DECODE onward because IRWrite=1 only in FETCH.
- Instruction latency: LDR 5 cycles; STR 4; data-processing 4; branch 3; Op=11 2.

Test Plan:
- Reset and idle: hold reset 2 cycles, release -> state=0 and IRWrite=1, NextPC=1 in the first free cycle, RegW=MemW=PCS=0 throughout reset.
- ADDS R1,R2,R3 (Op=00, Funct=6'b001001, Rd=1) -> states 0,1,6,8,0. In state 6: ALUControl=00, FlagW=11. In state 8: RegW=1, PCS=0.
- CMP immediate (Op=00, Funct=6'b110101) -> states 0,1,7,8. In state 7: ALUControl=01, FlagW=11, ALUSrcB=01. In state 8: NoWrite=1, RegW=1.
- LDR to PC (Op=01, Funct[0]=1, Rd=15) -> states 0,1,2,3,4,0. In state 4: ResultSrc=01, RegW=1, PCS=1.
- STR (Funct[0]=0) -> states 0,1,2,5,0 with MemW=1 only in state 5 and AdrSrc=1. B (Op=10) -> state 9 with PCS=1 and ALUSrcB=01, then FETCH.
- Reset asserted in state 3 -> state=0 on that edge and no RegW pulse follows. Op=11 -> returns to FETCH directly after DECODE with no write requests.
